// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: PC-mux select encoding used by the fetch stage.
package lc3b_types;

  typedef enum logic [1:0] {
    PCSEL_NEXT  = 2'b00,
    PCSEL_PRED  = 2'b01,
    PCSEL_REDIR = 2'b10,
    PCSEL_TRAP  = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter next-value logic (module sat_counter).
module sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_ctr,
  input  logic                i_inc,
  output logic [CTR_BITS-1:0] o_ctr
);

  localparam logic [CTR_BITS-1:0] CtrMax = {CTR_BITS{1'b1}};

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != CtrMax) o_ctr = i_ctr + CTR_BITS'(1);
    end else begin
      if (i_ctr != '0) o_ctr = i_ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB with per-entry saturating counters, mispredict detection and PC-mux select.
// Optional gshare counter indexing is enabled by defining BPU_GSHARE_EN.
module branch_predict_unit
  import lc3b_types::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] fetch_pc,
  input  logic        trap_ind,
  input  logic        wb_valid,
  input  logic        wb_br_ind,
  input  logic [15:0] wb_pc,
  input  logic        wb_taken,
  input  logic [15:0] wb_target,
  input  logic        wb_pred_taken,
  input  logic [15:0] wb_pred_target,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic [1:0]  pc_mux_sel
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 15 - IDX_W;
  localparam logic [CTR_BITS-1:0] CtrMax   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrAlloc = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CtrRst   = CtrAlloc - CTR_BITS'(1);

  logic                r_valid  [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [15:0]         r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [15:0]         r_mispredict_count;

  logic [IDX_W-1:0]    w_f_idx, w_f_cidx, w_u_idx, w_u_cidx;
  logic [TAG_W-1:0]    w_f_tag, w_u_tag;
  logic                w_f_hit, w_u_hit;
  logic                w_wr_entry, w_wr_ctr;
  logic [CTR_BITS-1:0] w_ctr_sat, w_ctr_d;
  pc_sel_t             w_sel;
  logic                w_unused;

  assign w_unused = ^{fetch_pc[0], wb_pc[0]};

  assign w_f_idx = fetch_pc[IDX_W:1];
  assign w_f_tag = fetch_pc[15:IDX_W+1];
  assign w_u_idx = wb_pc[IDX_W:1];
  assign w_u_tag = wb_pc[15:IDX_W+1];

`ifdef BPU_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // History only steers the counter; tag/target/valid stay PC-indexed.
  assign w_f_cidx = w_f_idx ^ r_ghr;
  assign w_u_cidx = w_u_idx ^ r_ghr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (wb_valid && wb_br_ind) begin
      r_ghr <= {r_ghr[IDX_W-2:0], wb_taken};
    end
  end
`else
  assign w_f_cidx = w_f_idx;
  assign w_u_cidx = w_u_idx;
`endif

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign pred_taken  = reset_n && w_f_hit && r_ctr[w_f_cidx][CTR_BITS-1];
  assign pred_target = r_target[w_f_idx];

  assign mispredict  = wb_valid && ((wb_pred_taken != wb_taken) ||
                                    (wb_taken && (wb_pred_target != wb_target)));
  assign redirect_pc = wb_taken ? wb_target : wb_pc + 16'd2;

  always_comb begin
    w_sel = PCSEL_NEXT;
    if (mispredict)      w_sel = PCSEL_REDIR;
    else if (trap_ind)   w_sel = PCSEL_TRAP;
    else if (pred_taken) w_sel = PCSEL_PRED;
  end
  assign pc_mux_sel = w_sel;

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .i_ctr (r_ctr[w_u_cidx]),
    .i_inc (wb_taken),
    .o_ctr (w_ctr_sat)
  );

  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // JSR/JMP are unconditional: install/refresh the entry and pin it strongly taken.
  always_comb begin
    w_wr_entry = 1'b0;
    w_wr_ctr   = 1'b0;
    w_ctr_d    = w_ctr_sat;
    if (wb_valid) begin
      if (!wb_br_ind) begin
        w_wr_entry = 1'b1;
        w_wr_ctr   = 1'b1;
        w_ctr_d    = CtrMax;
      end else if (w_u_hit) begin
        w_wr_entry = wb_taken;
        w_wr_ctr   = 1'b1;
      end else if (wb_taken) begin
        w_wr_entry = 1'b1;
        w_wr_ctr   = 1'b1;
        w_ctr_d    = CtrAlloc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CtrRst;
      end
      r_mispredict_count <= '0;
    end else begin
      if (w_wr_entry) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= wb_target;
      end
      if (w_wr_ctr) r_ctr[w_u_cidx] <= w_ctr_d;
      if (mispredict && (r_mispredict_count != 16'hFFFF)) begin
        r_mispredict_count <= r_mispredict_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default build, ENTRIES=16, CTR_BITS=2).
module tb_branch_predict_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] fetch_pc;
  logic        trap_ind;
  logic        wb_valid;
  logic        wb_br_ind;
  logic [15:0] wb_pc;
  logic        wb_taken;
  logic [15:0] wb_target;
  logic        wb_pred_taken;
  logic [15:0] wb_pred_target;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [1:0]  pc_mux_sel;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(
    .ENTRIES  (16),
    .CTR_BITS (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_pc       (fetch_pc),
    .trap_ind       (trap_ind),
    .wb_valid       (wb_valid),
    .wb_br_ind      (wb_br_ind),
    .wb_pc          (wb_pc),
    .wb_taken       (wb_taken),
    .wb_target      (wb_target),
    .wb_pred_taken  (wb_pred_taken),
    .wb_pred_target (wb_pred_target),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .pc_mux_sel     (pc_mux_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic br, input logic [15:0] pc, input logic tk,
                        input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
    wb_valid = v; wb_br_ind = br; wb_pc = pc; wb_taken = tk;
    wb_target = tgt; wb_pred_taken = ptk; wb_pred_target = ptgt;
  endtask

  task automatic idle_wb();
    set_wb(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  // Resolve one conditional branch at pc; prediction fields are left matching to avoid noise.
  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    set_wb(1'b1, 1'b1, pc, tk, tgt, tk, tgt);
    step();
    idle_wb();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trap_ind = 1'b0; fetch_pc = 16'h3000; idle_wb();
    step(); step();
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred_taken: got %0b expected 0", pred_taken);
    end
    checks++;
    if (dut.r_mispredict_count !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %h expected 0000", dut.r_mispredict_count);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (pred_taken !== 1'b0 || pc_mux_sel !== 2'b00) begin
      errors++;
      $display("FAIL after_reset: got pred=%0b sel=%b expected pred=0 sel=00", pred_taken,
               pc_mux_sel);
    end
  endtask

  task automatic test_taken_alloc();
    fetch_pc = 16'h3000;
    set_wb(1'b1, 1'b1, 16'h3000, 1'b1, 16'h3020, 1'b0, 16'h0000);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h3020 || pc_mux_sel !== 2'b10) begin
      errors++;
      $display("FAIL alloc_mispredict: got mp=%0b redir=%h sel=%b expected 1 3020 10",
               mispredict, redirect_pc, pc_mux_sel);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL no_bypass: got pred=%0b expected 0", pred_taken);
    end
    step();
    idle_wb();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 16'h3020 || pc_mux_sel !== 2'b01) begin
      errors++;
      $display("FAIL alloc_predict: got pred=%0b tgt=%h sel=%b expected 1 3020 01",
               pred_taken, pred_target, pc_mux_sel);
    end
  endtask

  task automatic test_not_taken();
    fetch_pc = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      resolve(16'h3000, 1'b0, 16'h3002);
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++; $display("FAIL not_taken_%0d: got pred=%0b expected 0", i, pred_taken);
      end
    end
    // Counter saturated at 0: one taken reaches 1 (not taken), the second reaches 2.
    resolve(16'h3000, 1'b1, 16'h3040);
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL sat_low_inc1: got pred=%0b expected 0", pred_taken);
    end
    resolve(16'h3000, 1'b1, 16'h3040);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 16'h3040) begin
      errors++;
      $display("FAIL sat_low_inc2: got pred=%0b tgt=%h expected 1 3040", pred_taken,
               pred_target);
    end
  endtask

  task automatic test_alias();
    fetch_pc = 16'h3020;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pc_mux_sel !== 2'b00) begin
      errors++;
      $display("FAIL alias_miss: got pred=%0b sel=%b expected 0 00", pred_taken, pc_mux_sel);
    end
    resolve(16'h3020, 1'b1, 16'h3100);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 16'h3100) begin
      errors++;
      $display("FAIL alias_alloc: got pred=%0b tgt=%h expected 1 3100", pred_taken,
               pred_target);
    end
    fetch_pc = 16'h3000;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL alias_evicted: got pred=%0b expected 0", pred_taken);
    end
  endtask

  task automatic test_non_branch();
    fetch_pc = 16'h3020;
    resolve(16'h3020, 1'b0, 16'h3022);
    resolve(16'h3020, 1'b0, 16'h3022);
    set_wb(1'b1, 1'b0, 16'h3020, 1'b1, 16'h3200, 1'b1, 16'h3200);
    step();
    idle_wb();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 16'h3200) begin
      errors++;
      $display("FAIL jsr_max: got pred=%0b tgt=%h expected 1 3200", pred_taken, pred_target);
    end
    // From max (3) one not-taken still predicts taken.
    resolve(16'h3020, 1'b0, 16'h3022);
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL jsr_then_nt: got pred=%0b expected 1", pred_taken);
    end
  endtask

  task automatic test_mispredict_redirect();
    fetch_pc = 16'h5000;
    trap_ind = 1'b1;
    set_wb(1'b1, 1'b1, 16'h30FE, 1'b0, 16'h0000, 1'b1, 16'h0000);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h3100 || pc_mux_sel !== 2'b10) begin
      errors++;
      $display("FAIL mp_trap: got mp=%0b redir=%h sel=%b expected 1 3100 10", mispredict,
               redirect_pc, pc_mux_sel);
    end
    wb_pc = 16'hFFFE;
    #1;
    checks++;
    if (redirect_pc !== 16'h0000) begin
      errors++; $display("FAIL redir_wrap: got %h expected 0000", redirect_pc);
    end
    set_wb(1'b1, 1'b1, 16'h3000, 1'b1, 16'h1236, 1'b1, 16'h1234);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h1236) begin
      errors++;
      $display("FAIL mp_target: got mp=%0b redir=%h expected 1 1236", mispredict, redirect_pc);
    end
    wb_pred_target = 16'h1236;
    #1;
    checks++;
    if (mispredict !== 1'b0 || pc_mux_sel !== 2'b11) begin
      errors++;
      $display("FAIL correct_trap: got mp=%0b sel=%b expected 0 11", mispredict, pc_mux_sel);
    end
    set_wb(1'b1, 1'b1, 16'h3000, 1'b0, 16'h1111, 1'b0, 16'h2222);
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL nt_target_ignored: got mp=%0b expected 0", mispredict);
    end
    set_wb(1'b0, 1'b1, 16'h3000, 1'b1, 16'h1111, 1'b0, 16'h2222);
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL mp_needs_valid: got mp=%0b expected 0", mispredict);
    end
    trap_ind = 1'b0;
    idle_wb();
  endtask

  task automatic test_mispredict_count();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    // Not-taken miss at an unused PC: counts mispredicts without touching the table.
    set_wb(1'b1, 1'b1, 16'h4002, 1'b0, 16'h0000, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (dut.r_mispredict_count !== 16'd5) begin
      errors++; $display("FAIL count_5: got %h expected 0005", dut.r_mispredict_count);
    end
    for (int i = 5; i < 70000; i++) step();
    checks++;
    if (dut.r_mispredict_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_sat: got %h expected ffff", dut.r_mispredict_count);
    end
    idle_wb();
  endtask

  task automatic test_reset_mid_update();
    fetch_pc = 16'h3020;
    resolve(16'h3020, 1'b1, 16'h3300);
    resolve(16'h3020, 1'b1, 16'h3300);
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL pre_reset_hit: got pred=%0b expected 1", pred_taken);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pc_mux_sel !== 2'b00) begin
      errors++;
      $display("FAIL in_reset: got pred=%0b sel=%b expected 0 00", pred_taken, pc_mux_sel);
    end
    set_wb(1'b1, 1'b1, 16'h3000, 1'b1, 16'h3400, 1'b0, 16'h0000);
    step();
    reset_n = 1'b1;
    idle_wb();
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_clears_3020: got pred=%0b expected 0", pred_taken);
    end
    fetch_pc = 16'h3000;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_beats_update: got pred=%0b expected 0", pred_taken);
    end
    checks++;
    if (dut.r_mispredict_count !== 16'h0000) begin
      errors++; $display("FAIL reset_count_mid: got %h expected 0000", dut.r_mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_taken_alloc();
    test_not_taken();
    test_alias();
    test_non_branch();
    test_mispredict_redirect();
    test_mispredict_count();
    test_reset_mid_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
